// File: rtl/defs_pkg.sv
// ============================================================================
// Module : defs
// Brief  : Shared UART bit timing, parity encodings and transmitter states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package defs;
  localparam int N          = 15;
  localparam int count_bits = 4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module : uart_bit_timer
// Brief  : Oversample counter 0..N with synchronous clear and bit-end strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_timer
  import defs::*;
(
  input  logic tick,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  logic [count_bits-1:0] count;

  assign bit_end = (count == count_bits'(N));

  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : UART transmitter, 7/8 data bits, optional parity, 1/2 stop bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx
  import defs::*;
(
  input  logic       tick,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       d_num,
  input  logic       s_num,
  input  logic [1:0] par,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t  state;
  logic [7:0] data_r;
  logic [7:0] shift_r;
  logic       d_num_r;
  logic       s_num_r;
  logic [1:0] par_r;
  logic [2:0] bit_idx;
  logic       stop_cnt;

  logic       bit_end;
  logic [7:0] par_data;
  logic       par_bit;
  logic       par_en;
  logic [2:0] last_idx;

  uart_bit_timer u_bit_timer (
    .tick    (tick),
    .reset_n (reset_n),
    .clear   (state == IDLE),
    .bit_end (bit_end)
  );

  // Bit 7 only contributes when it is actually transmitted.
  assign par_data = d_num_r ? data_r : {1'b0, data_r[6:0]};
  assign par_bit  = (par_r == PAR_ODD) ? ~^par_data : ^par_data;
  assign par_en   = (par_r == PAR_ODD) || (par_r == PAR_EVEN);
  assign last_idx = d_num_r ? 3'd7 : 3'd6;

  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_r   <= '0;
      shift_r  <= '0;
      d_num_r  <= 1'b0;
      s_num_r  <= 1'b0;
      par_r    <= PAR_NONE;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            data_r  <= data_in;
            shift_r <= data_in;
            d_num_r <= d_num;
            s_num_r <= s_num;
            par_r   <= par;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            tx      <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx == last_idx) begin
              if (par_en) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (s_num_r && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state    <= IDLE;
              stop_cnt <= 1'b0;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module : tb_uart_tx
// Brief  : Directed self-checking bench for uart_tx (16 ticks per bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic       tick;
  logic       reset_n;
  logic       tx_start;
  logic [7:0] data_in;
  logic       d_num;
  logic       s_num;
  logic [1:0] par;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic tx_log   [0:511];
  logic busy_log [0:511];
  logic done_log [0:511];

  uart_tx dut (
    .tick     (tick),
    .reset_n  (reset_n),
    .tx_start (tx_start),
    .data_in  (data_in),
    .d_num    (d_num),
    .s_num    (s_num),
    .par      (par),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial tick = 1'b0;
  always #5 tick = ~tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample n is taken at the falling edge after the n-th rising edge following
  // the accepting edge; inputs are then updated at that same falling edge.
  task automatic capture(input int len, input int drop_at, input int pulse_at,
                         input int rst_at, input int chg_at, input logic [7:0] chg_data);
    for (int n = 1; n <= len; n++) begin
      @(negedge tick);
      tx_log[n]   = tx;
      busy_log[n] = tx_busy;
      done_log[n] = tx_done;
      if (n == drop_at) tx_start = 1'b0;
      if (n == chg_at) data_in = chg_data;
      if (pulse_at > 0 && n == pulse_at) tx_start = 1'b1;
      if (pulse_at > 0 && n == pulse_at + 1) tx_start = 1'b0;
      if (n == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_tx", 32'(tx), 32'd1);
        check_eq("rst_mid_busy", 32'(tx_busy), 32'd0);
      end
    end
  endtask

  function automatic logic [31:0] decode(input int base, input int nbits);
    logic [31:0] v = '0;
    for (int k = 0; k < nbits; k++) v[k] = tx_log[base + 16*k + 8];
    return v;
  endfunction

  function automatic int glitches(input int base, input int nbits);
    int g = 0;
    for (int k = 0; k < nbits; k++)
      for (int s = 1; s <= 16; s++)
        if (tx_log[base + 16*k + s] !== tx_log[base + 16*k + 8]) g++;
    return g;
  endfunction

  function automatic int first_done(input int len);
    for (int n = 1; n <= len; n++) if (done_log[n] === 1'b1) return n;
    return -1;
  endfunction

  function automatic int count_done(input int len);
    int c = 0;
    for (int n = 1; n <= len; n++) if (done_log[n] === 1'b1) c++;
    return c;
  endfunction

  task automatic launch(input logic [7:0] d, input logic dn, input logic sn, input logic [1:0] p);
    @(negedge tick);
    data_in  = d;
    d_num    = dn;
    s_num    = sn;
    par      = p;
    tx_start = 1'b1;
  endtask

  task automatic single_frame(input string tag, input logic [7:0] d, input logic dn,
                              input logic sn, input logic [1:0] p,
                              input logic [31:0] exp_bits, input int nbits, input int pulse_at);
    int len;
    len = nbits*16 + 4;
    launch(d, dn, sn, p);
    capture(len, 1, pulse_at, 0, 2, ~d);
    check_eq({tag, "_bits"}, decode(0, nbits), exp_bits);
    check_eq({tag, "_stable"}, 32'(glitches(0, nbits)), 32'd0);
    check_eq({tag, "_busy_first"}, 32'(busy_log[1]), 32'd1);
    check_eq({tag, "_busy_last"}, 32'(busy_log[nbits*16]), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy_log[nbits*16 + 1]), 32'd0);
    check_eq({tag, "_done_at"}, 32'(first_done(len)), 32'(nbits*16 + 1));
    check_eq({tag, "_done_cnt"}, 32'(count_done(len)), 32'd1);
    check_eq({tag, "_idle_tx"}, 32'(tx_log[len]), 32'd1);
  endtask

  initial begin
    int busy_low;
    reset_n  = 1'b0;
    tx_start = 1'b0;
    data_in  = 8'h00;
    d_num    = 1'b1;
    s_num    = 1'b0;
    par      = 2'b00;
    repeat (3) @(negedge tick);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(tx_busy), 32'd0);
    check_eq("reset_done", 32'(tx_done), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge tick);

    // 8N1 0xA5: start 0, data A5 LSB first, stop 1
    single_frame("8N1_A5", 8'hA5, 1'b1, 1'b0, 2'b00, {22'd0, 1'b1, 8'hA5, 1'b0}, 10, 0);
    // 7O2 0xC3: data 0x43 (7 bits), odd parity 0, two stops
    single_frame("7O2_C3", 8'hC3, 1'b0, 1'b1, 2'b01, {21'd0, 2'b11, 1'b0, 7'h43, 1'b0}, 11, 0);
    // 8E1 0x07: even parity 1
    single_frame("8E1_07", 8'h07, 1'b1, 1'b0, 2'b10, {21'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
    // Request pulsed mid-frame must be ignored
    single_frame("pulse40", 8'h5A, 1'b1, 1'b0, 2'b00, {22'd0, 1'b1, 8'h5A, 1'b0}, 10, 40);

    // Back-to-back: tx_start held, 0x55 then 0xAA
    launch(8'h55, 1'b1, 1'b0, 2'b00);
    capture(330, 162, 0, 0, 2, 8'hAA);
    check_eq("b2b_f1_bits", decode(0, 10), {22'd0, 1'b1, 8'h55, 1'b0});
    check_eq("b2b_gap_tx", 32'(tx_log[161]), 32'd1);
    check_eq("b2b_gap_done", 32'(done_log[161]), 32'd1);
    check_eq("b2b_f2_start", 32'(tx_log[162]), 32'd0);
    check_eq("b2b_f2_bits", decode(161, 10), {22'd0, 1'b1, 8'hAA, 1'b0});
    check_eq("b2b_f2_stable", 32'(glitches(161, 10)), 32'd0);
    busy_low = 0;
    for (int n = 1; n <= 321; n++) if (busy_log[n] === 1'b0) busy_low++;
    check_eq("b2b_busy_low", 32'(busy_low), 32'd1);
    check_eq("b2b_done_cnt", 32'(count_done(330)), 32'd2);
    check_eq("b2b_done2_at", 32'(done_log[322]), 32'd1);

    // Reset at tick 70 of an 8N1 frame, then a clean frame
    repeat (4) @(negedge tick);
    launch(8'hA5, 1'b1, 1'b0, 2'b00);
    capture(80, 1, 0, 70, 0, 8'h00);
    check_eq("rst_no_done", 32'(count_done(80)), 32'd0);
    check_eq("rst_hold_tx", 32'(tx_log[80]), 32'd1);
    @(negedge tick);
    reset_n = 1'b1;
    repeat (2) @(negedge tick);
    single_frame("post_rst_3C", 8'h3C, 1'b1, 1'b0, 2'b00, {22'd0, 1'b1, 8'h3C, 1'b0}, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
